// File: rtl/twos_complement_serial.sv
// Bit-serial two's-complement conditioner (pass / negate / abs) with valid/ready handshakes.
// Optional build macro TWOS_COMP_SAT_EN saturates the overflow case to the most-positive value.
module twos_complement_serial #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`ifdef TWOS_COMP_SAT_EN
  localparam logic [WIDTH-1:0] SAT_VAL  = {1'b0, {(WIDTH-1){1'b1}}};
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] cnt;
  logic             seen_one;
  logic             inv;

  logic             accept;
  logic             last_bit;
  logic             bit_in;
  logic             res_bit;
  logic [WIDTH-1:0] res_shift;
  logic             ovf_det;

  assign accept    = in_valid & in_ready;
  assign last_bit  = (cnt == LAST_CNT);
  assign bit_in    = opnd[0];
  // Copy up to and including the first 1, invert everything after it.
  assign res_bit   = (inv & seen_one) ? ~bit_in : bit_in;
  assign res_shift = {res_bit, res[WIDTH-1:1]};
  // Only the most-negative operand reaches its MSB without having seen a 1.
  assign ovf_det   = inv & bit_in & ~seen_one;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = SHIFT;
      SHIFT:   if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // in_ready is masked by reset so nothing is offered while the block is held.
  always_comb begin
    in_ready  = (state == IDLE) & ~reset;
    out_valid = (state == DONE);
  end

  // NOTE: every datapath register is reset; a mid-operation reset must leave no stale flags behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opnd     <= '0;
      res      <= '0;
      cnt      <= '0;
      seen_one <= 1'b0;
      inv      <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            opnd     <= in_data;
            res      <= '0;
            cnt      <= '0;
            seen_one <= 1'b0;
            unique case (in_mode)
              2'b01:   inv <= 1'b1;
              2'b10:   inv <= in_data[WIDTH-1];
              default: inv <= 1'b0;
            endcase
          end
        end
        SHIFT: begin
          opnd     <= opnd >> 1;
          res      <= res_shift;
          cnt      <= cnt + CNT_W'(1);
          seen_one <= seen_one | bit_in;
          if (last_bit) begin
            out_ovf  <= ovf_det;
`ifdef TWOS_COMP_SAT_EN
            out_data <= ovf_det ? SAT_VAL : res_shift;
`else
            out_data <= res_shift;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
